sdr_wb_resp_mem: RTL

//  Synthesizable Wishbone B3 responder (slave) backed by an on-chip byte-enabled memory.

---
 rtl/sdr_wb_pkg.sv | 7 +
 rtl/sdr_wb_bemem.sv | 18 +
 rtl/sdr_wb_resp_mem.sv | 89 ++++++++
 3 files changed

// File: rtl/sdr_wb_pkg.sv
// sdr_wb_pkg: shared Wishbone cycle-type constants and responder state type
package sdr_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic [1:0] {IDLE, WAIT, XFER} wb_state_e;
endpackage

// File: rtl/sdr_wb_bemem.sv
// sdr_wb_bemem: word-wide memory with per-byte write enable, sync write, async read
module sdr_wb_bemem #(
  parameter int DW     = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [DW/8-1:0]   be_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [DW-1:0]     wdata_i,
  output logic [DW-1:0]     rdata_o
);
  logic [DW-1:0] mem_q [2**MEM_AW];
  always_ff @(posedge clk_i)
    for (int i = 0; i < DW/8; i++)
      if (we_i && be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/sdr_wb_resp_mem.sv
// sdr_wb_resp_mem: Wishbone B3 responder backed by byte-enabled on-chip memory,
// serving classic cycles and incrementing bursts with programmable wait states.
module sdr_wb_resp_mem
  import sdr_wb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int MEM_AW = 10
) (
  input  logic            wb_clk_i,
  input  logic            wb_resetn,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [2:0]      wb_cti_i,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [3:0]      cfg_wait,
  output logic [15:0]     wr_beats,
  output logic [15:0]     rd_beats
);
  localparam int OFF = $clog2(DW / 8);
  wb_state_e         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              we_q, we_d, req, ack;
  logic [15:0]       wr_q, rd_q;
  logic [DW-1:0]     rdata;
  logic              unused_addr;
  assign unused_addr = ^{wb_addr_i[AW-1:MEM_AW+OFF], wb_addr_i[OFF-1:0]};
  assign req = wb_cyc_i && wb_stb_i;
  // ack follows the live strobe so a paused burst beat is never acknowledged
  assign ack = (state_q == XFER) && req;
  assign wb_ack_o = ack;
  assign wb_dat_o = (ack && !we_q) ? rdata : '0;
  assign wr_beats = wr_q;
  assign rd_beats = rd_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: if (req) begin
        addr_d  = wb_addr_i[MEM_AW+OFF-1:OFF];
        we_d    = wb_we_i;
        cnt_d   = cfg_wait - 4'd1;
        state_d = (cfg_wait == 4'd0) ? XFER : WAIT;
      end
      WAIT: begin
        state_d = !wb_cyc_i ? IDLE : (cnt_q == 4'd0) ? XFER : WAIT;
        cnt_d   = (wb_cyc_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      end
      XFER: if (!wb_cyc_i) state_d = IDLE;
      else if (ack) begin
        addr_d  = addr_q + 1'b1;
        state_d = (wb_cti_i == CTI_INCR) ? XFER : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_resetn)
    if (!wb_resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      if (ack && we_q) wr_q <= wr_q + 16'd1;
      if (ack && !we_q) rd_q <= rd_q + 16'd1;
    end
  sdr_wb_bemem #(.DW(DW), .MEM_AW(MEM_AW)) u_mem (
    .clk_i  (wb_clk_i),
    .we_i   (ack && we_q),
    .be_i   (wb_sel_i),
    .addr_i (addr_q),
    .wdata_i(wb_dat_i),
    .rdata_o(rdata)
  );
endmodule
